mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter and access sequencer in front of the memory interface bus (read enable, write enable, byte enable, address, write data, read data). It shares the single bus port between the CPU data port (master 0) and a secondary master (master 1, e.g. DMA or a debug loader). It registers the winning request and drives the bus for exactly one access. It waits out the block-RAM read latency, then returns data with a one-cycle acknowledge.

## Interface
Parameters:
- READ_LATENCY, 1: cycles from first bus cycle with address driven until iReadData is valid; legal 1..7.

Ports:
- iCLK  in  1  system clock; all state on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iM0Req, iM1Req  in  1  access request; held high until the matching ack.
- iM0Write, iM1Write  in  1  1 = write, 0 = read.
- iM0ByteEnable, iM1ByteEnable  in  4  byte lanes.
- iM0Address, iM1Address  in  32  byte address.
- iM0WriteData, iM1WriteData  in  32  write data.
- oM0Ack, oM1Ack  out  1  one-cycle completion pulse.
- oM0ReadData, oM1ReadData  out  32  read data; valid in the ack cycle, held until the next read completion for that master.
- oReadEnable, oWriteEnable  out  1  bus strobes.
- oByteEnable  out  4  bus byte enable.
- oAddress, oWriteData  out  32  bus address and data.
- iReadData  in  32  bus read data (combinational from memory mux).
- oGrant  out  2  one-hot owner of current access; 2'b00 when idle.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any request is pending, arbitrate and latch the winner's write, byte-enable, address and write data into the bus output registers. Set oGrant and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: the bus is driven for 1 cycle with oWriteEnable=write or oReadEnable=~write.
  - Write goes to DONE, and oWriteEnable drops on the same edge. The memory sees exactly one write-enable cycle.
  - Read loads the wait counter with READ_LATENCY-1 and goes to WAIT. If READ_LATENCY=1, WAIT lasts 1 cycle.
- WAIT: address and oReadEnable stay stable. The counter decrements each cycle.
  - On the cycle the counter is 0, capture iReadData into the owner's ReadData register.
  - On the same edge, deassert the bus and go to DONE.
- DONE: the owner's Ack is high for this cycle only. The bus is idle (all bus outputs 0) and oGrant is cleared on exit. Requests are ignored in this cycle. Next state is IDLE.
- The master must drop Req, or present a new request, in the cycle after its Ack. A Req still high in the IDLE that follows is treated as a new access.
- A Req deasserted before Ack does not abort the access. The access completes and Ack still pulses.
- Bus outputs are 0 whenever the state is not ACCESS or WAIT. This covers oByteEnable, oAddress and oWriteData.
- The last-grant pointer (1 bit) updates on every grant.

## Timing
- Reset: the state becomes IDLE on the first edge with iRST high. At that point every output is 0, the ReadData registers are 0, and the last-grant pointer is 1, so master 0 wins the first tie.
- Reset mid-access (ACCESS/WAIT/DONE): the access is abandoned, no Ack is issued and the bus is deasserted. A pending write in ACCESS when reset is sampled is not guaranteed to commit.
- Write latency: request seen in cycle 0 (IDLE), bus write in cycle 1, Ack in cycle 2. Throughput is 1 write per 3 cycles.
- Read latency: bus read in cycles 1..READ_LATENCY+1, Ack with data in cycle READ_LATENCY+2. Default is Ack in cycle 3.
- Simultaneous requests are resolved in IDLE only. There is no preemption.
- All outputs are registered. There is no combinational path from the request inputs to the outputs.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie, the master not granted last wins. Two saturating masters alternate M0, M1, M0, ...
- Not defined: fixed priority, where master 0 always wins a tie. The pointer logic is removed, and master 1 starves while master 0 keeps requesting.

## Test plan
- Reset: iRST high for 2 cycles with both Req high -> all outputs 0, no Ack. After release, the first grant is oGrant=2'b01.
- M0 write, addr 0x10010000, data 0xDEADBEEF, BE 4'hF -> oWriteEnable high only in cycle 1 with those values on the bus; oM0Ack pulses in cycle 2; oM1Ack stays 0.
- M1 read with READ_LATENCY=1, memory returns 0x12345678 -> oReadEnable high in cycles 1-2, oM1ReadData=0x12345678 with oM1Ack in cycle 3. The value holds after Ack.
- Both Req held continuously, with MEM_ARB_ROUND_ROBIN_EN -> Ack order M0, M1, M0, M1, one grant per access. Without the macro -> only M0 is acked.
- iRST pulsed during WAIT of an M0 read -> no oM0Ack, bus 0 on the next cycle. After release, a fresh M0 read completes normally.
- READ_LATENCY=3, M0 read -> oReadEnable high for 4 cycles with a stable address; Ack in cycle 5 carries the data present in cycle 4.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and single-access sequencer in front of the memory bus; all outputs registered.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break, otherwise master 0 has fixed priority.
module mem_bus_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iM0Req,
    input  logic        iM0Write,
    input  logic [3:0]  iM0ByteEnable,
    input  logic [31:0] iM0Address,
    input  logic [31:0] iM0WriteData,
    input  logic        iM1Req,
    input  logic        iM1Write,
    input  logic [3:0]  iM1ByteEnable,
    input  logic [31:0] iM1Address,
    input  logic [31:0] iM1WriteData,
    output logic        oM0Ack,
    output logic [31:0] oM0ReadData,
    output logic        oM1Ack,
    output logic [31:0] oM1ReadData,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData,
    output logic [1:0]  oGrant
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

    state_t      state;
    logic [2:0]  waitCount;
    logic        owner;
    logic        pickM1;
    logic        selWrite;
    logic [3:0]  selByteEnable;
    logic [31:0] selAddress;
    logic [31:0] selWriteData;
    logic        accessEnd;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        lastGrant;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pickM1 = iM1Req && !iM0Req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (iM0Req && iM1Req) begin
            pickM1 = !lastGrant;
        end
`endif
        selWrite      = pickM1 ? iM1Write      : iM0Write;
        selByteEnable = pickM1 ? iM1ByteEnable : iM0ByteEnable;
        selAddress    = pickM1 ? iM1Address    : iM0Address;
        selWriteData  = pickM1 ? iM1WriteData  : iM0WriteData;
    end

    // A write ends after its single ACCESS cycle; a read ends when the wait counter reaches zero.
    assign accessEnd = (state == ACCESS && oWriteEnable) || (state == WAIT && waitCount == 3'd0);

    // NOTE: sequential state uses non-blocking assignments only, so the later accessEnd block wins cleanly.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            waitCount    <= 3'd0;
            owner        <= 1'b0;
            oM0Ack       <= 1'b0;
            oM1Ack       <= 1'b0;
            oM0ReadData  <= 32'd0;
            oM1ReadData  <= 32'd0;
            oReadEnable  <= 1'b0;
            oWriteEnable <= 1'b0;
            oByteEnable  <= 4'd0;
            oAddress     <= 32'd0;
            oWriteData   <= 32'd0;
            oGrant       <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastGrant    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (iM0Req || iM1Req) begin
                        owner        <= pickM1;
                        oWriteEnable <= selWrite;
                        oReadEnable  <= !selWrite;
                        oByteEnable  <= selByteEnable;
                        oAddress     <= selAddress;
                        oWriteData   <= selWriteData;
                        oGrant       <= pickM1 ? 2'b10 : 2'b01;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        lastGrant    <= pickM1;
`endif
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!oWriteEnable) begin
                        waitCount <= WAIT_LOAD;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCount == 3'd0) begin
                        if (owner) oM1ReadData <= iReadData;
                        else       oM0ReadData <= iReadData;
                    end else begin
                        waitCount <= waitCount - 3'd1;
                    end
                end
                DONE: begin
                    oM0Ack <= 1'b0;
                    oM1Ack <= 1'b0;
                    oGrant <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accessEnd) begin
                oReadEnable  <= 1'b0;
                oWriteEnable <= 1'b0;
                oByteEnable  <= 4'd0;
                oAddress     <= 32'd0;
                oWriteData   <= 32'd0;
                oM0Ack       <= !owner;
                oM1Ack       <= owner;
                state        <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks, negedge monitors pop and compare.
module tb_mem_bus_arbiter;
    localparam int RL1 = 1;
    localparam int RL3 = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        master;
        logic        isRead;
        logic [31:0] data;
        int          ackCycle;
    } exp_t;

    logic        iCLK;
    logic        iRST;
    logic        iM0Req, iM0Write, iM1Req, iM1Write;
    logic [3:0]  iM0ByteEnable, iM1ByteEnable;
    logic [31:0] iM0Address, iM0WriteData, iM1Address, iM1WriteData;
    logic        oM0Ack, oM1Ack, oReadEnable, oWriteEnable;
    logic [31:0] oM0ReadData, oM1ReadData, oAddress, oWriteData, iReadData;
    logic [3:0]  oByteEnable;
    logic [1:0]  oGrant;

    logic        d3M0Req, d3M0Write, d3Zero1;
    logic [3:0]  d3M0ByteEnable, d3Zero4;
    logic [31:0] d3M0Address, d3M0WriteData, d3Zero32;
    logic        d3M0Ack, d3M1Ack, d3ReadEnable, d3WriteEnable;
    logic [31:0] d3M0ReadData, d3M1ReadData, d3Address, d3WriteData, d3ReadData;
    logic [3:0]  d3ByteEnable;
    logic [1:0]  d3Grant;

    int          cyc = 0;
    int          rdCycle = -1;
    int          rd3Cycle = -1;
    logic [31:0] rdWord = 32'd0;
    logic [31:0] rd3Word = 32'd0;
    int          errors = 0;
    int          checks = 0;
    exp_t        expQ[$];
    exp_t        exp3Q[$];
    exp_t        mon;
    exp_t        mon3;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Memory returns the intended word only in the capture cycle, its complement otherwise.
    assign iReadData  = (cyc == rdCycle)  ? rdWord  : ~rdWord;
    assign d3ReadData = (cyc == rd3Cycle) ? rd3Word : ~rd3Word;

    mem_bus_arbiter #(.READ_LATENCY(RL1)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iM0Req(iM0Req), .iM0Write(iM0Write), .iM0ByteEnable(iM0ByteEnable),
        .iM0Address(iM0Address), .iM0WriteData(iM0WriteData),
        .iM1Req(iM1Req), .iM1Write(iM1Write), .iM1ByteEnable(iM1ByteEnable),
        .iM1Address(iM1Address), .iM1WriteData(iM1WriteData),
        .oM0Ack(oM0Ack), .oM0ReadData(oM0ReadData), .oM1Ack(oM1Ack), .oM1ReadData(oM1ReadData),
        .oReadEnable(oReadEnable), .oWriteEnable(oWriteEnable), .oByteEnable(oByteEnable),
        .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData), .oGrant(oGrant)
    );

    mem_bus_arbiter #(.READ_LATENCY(RL3)) dut3 (
        .iCLK(iCLK), .iRST(iRST),
        .iM0Req(d3M0Req), .iM0Write(d3M0Write), .iM0ByteEnable(d3M0ByteEnable),
        .iM0Address(d3M0Address), .iM0WriteData(d3M0WriteData),
        .iM1Req(d3Zero1), .iM1Write(d3Zero1), .iM1ByteEnable(d3Zero4),
        .iM1Address(d3Zero32), .iM1WriteData(d3Zero32),
        .oM0Ack(d3M0Ack), .oM0ReadData(d3M0ReadData), .oM1Ack(d3M1Ack), .oM1ReadData(d3M1ReadData),
        .oReadEnable(d3ReadEnable), .oWriteEnable(d3WriteEnable), .oByteEnable(d3ByteEnable),
        .oAddress(d3Address), .oWriteData(d3WriteData), .iReadData(d3ReadData), .oGrant(d3Grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
        end
    endtask

    task automatic checkBus(input string tag, input logic re, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] grant);
        check({tag, "_ctl"},  32'({oReadEnable, oWriteEnable, oByteEnable, oGrant}), 32'({re, we, be, grant}));
        check({tag, "_addr"}, oAddress, addr);
        check({tag, "_wdata"}, oWriteData, wd);
    endtask

    task automatic pushExp(input bit toDut3, input logic m, input logic rd, input logic [31:0] d, input int ackCycle);
        exp_t e;
        e.master = m;
        e.isRead = rd;
        e.data = d;
        e.ackCycle = ackCycle;
        if (toDut3) exp3Q.push_back(e);
        else        expQ.push_back(e);
    endtask

    task automatic checkResetState();
        checkBus("reset", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00);
        check("reset_rdata", oM0ReadData | oM1ReadData, 32'h0);
        check("reset_dut3", 32'({d3ReadEnable, d3WriteEnable, d3Grant, d3M0Ack, d3M1Ack}), 32'h0);
    endtask

    task automatic doReset(input int n);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        repeat (n) begin
            @(posedge iCLK);
            @(negedge iCLK);
            checkResetState();
        end
        iRST = 1'b0;
    endtask

    // One access on the RL1 instance; bus is checked every cycle through the cycle after Ack.
    task automatic doAccess(input logic m, input logic wr, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] memWord);
        int c0;
        int done;
        logic [1:0] g;
        @(posedge iCLK); #1;
        c0 = cyc;
        done = wr ? 2 : RL1 + 2;
        g = m ? 2'b10 : 2'b01;
        if (m) begin
            iM1Req = 1'b1; iM1Write = wr; iM1ByteEnable = be; iM1Address = addr; iM1WriteData = wd;
        end else begin
            iM0Req = 1'b1; iM0Write = wr; iM0ByteEnable = be; iM0Address = addr; iM0WriteData = wd;
        end
        if (!wr) begin
            rdWord = memWord;
            rdCycle = c0 + done - 1;
        end
        pushExp(1'b0, m, !wr, memWord, c0 + done);
        for (int k = 1; k <= done + 1; k++) begin
            @(posedge iCLK); #1;
            if (k == done) begin
                iM0Req = 1'b0;
                iM1Req = 1'b0;
            end
            @(negedge iCLK);
            if (k < done)       checkBus("bus_active", !wr, wr, be, addr, wd, g);
            else if (k == done) checkBus("bus_done", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, g);
            else                checkBus("bus_after", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00);
        end
        if (!wr) check("rdata_hold", m ? oM1ReadData : oM0ReadData, memWord);
    endtask

    always @(negedge iCLK) begin
        if (oM0Ack || oM1Ack) begin
            if (expQ.size() == 0) begin
                check("spurious_ack", 32'({oM1Ack, oM0Ack}), 32'h0);
            end else begin
                mon = expQ.pop_front();
                check("ack_master", 32'({oM1Ack, oM0Ack}), mon.master ? 32'h2 : 32'h1);
                check("ack_cycle", cyc, mon.ackCycle);
                if (mon.isRead) check("ack_rdata", mon.master ? oM1ReadData : oM0ReadData, mon.data);
            end
        end
    end

    always @(negedge iCLK) begin
        if (d3M0Ack || d3M1Ack) begin
            if (exp3Q.size() == 0) begin
                check("spurious_ack3", 32'({d3M1Ack, d3M0Ack}), 32'h0);
            end else begin
                mon3 = exp3Q.pop_front();
                check("ack3_master", 32'({d3M1Ack, d3M0Ack}), 32'h1);
                check("ack3_cycle", cyc, mon3.ackCycle);
                check("ack3_rdata", d3M0ReadData, mon3.data);
            end
        end
    end

    initial begin
        int c0;
        logic [1:0] g;
        logic m;
        iRST = 1'b1;
        iM0Req = 1'b1; iM0Write = 1'b1; iM0ByteEnable = 4'h3; iM0Address = 32'h0000_0100; iM0WriteData = 32'hA5A5_A5A5;
        iM1Req = 1'b1; iM1Write = 1'b0; iM1ByteEnable = 4'hF; iM1Address = 32'h0000_0200; iM1WriteData = 32'h0;
        d3M0Req = 1'b0; d3M0Write = 1'b0; d3M0ByteEnable = 4'h0; d3M0Address = 32'h0; d3M0WriteData = 32'h0;
        d3Zero1 = 1'b0; d3Zero4 = 4'h0; d3Zero32 = 32'h0;

        // Reset held two cycles with both requests pending, then master 0 must win the first tie.
        repeat (2) begin
            @(posedge iCLK);
            @(negedge iCLK);
            checkResetState();
        end
        iRST = 1'b0;
        c0 = cyc;
        pushExp(1'b0, 1'b0, 1'b0, 32'h0, c0 + 2);
        @(posedge iCLK); #1;
        iM0Req = 1'b0;
        iM1Req = 1'b0;
        @(negedge iCLK);
        checkBus("first_grant", 1'b0, 1'b1, 4'h3, 32'h0000_0100, 32'hA5A5_A5A5, 2'b01);
        @(negedge iCLK);
        checkBus("first_done", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01);

        doAccess(1'b0, 1'b1, 4'hF, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0);
        doAccess(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 32'h1234_5678);
        doAccess(1'b0, 1'b1, 4'h5, 32'h0000_0FFC, 32'h0102_0304, 32'h0);
        check("m1_rdata_hold_long", oM1ReadData, 32'h1234_5678);
        doAccess(1'b0, 1'b0, 4'hC, 32'h0000_0040, 32'h0, 32'h5A5A_0F0F);

        // Reset during WAIT of an M0 read: access abandoned, no Ack, bus idle.
        @(posedge iCLK); #1;
        c0 = cyc;
        iM0Req = 1'b1; iM0Write = 1'b0; iM0ByteEnable = 4'hF; iM0Address = 32'h0000_0080; iM0WriteData = 32'h0;
        rdWord = 32'h7777_8888;
        rdCycle = c0 + 2;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST = 1'b1;
        iM0Req = 1'b0;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        @(negedge iCLK);
        checkBus("abort", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00);
        check("abort_rdata", oM0ReadData, 32'h0);
        doAccess(1'b0, 1'b0, 4'hF, 32'h0000_0044, 32'h0, 32'hCAFE_F00D);

        // Both masters saturating with writes for four accesses.
        doReset(1);
        @(posedge iCLK); #1;
        c0 = cyc;
        iM0Req = 1'b1; iM0Write = 1'b1; iM0ByteEnable = 4'hF; iM0Address = 32'h0000_1000; iM0WriteData = 32'h1111_1111;
        iM1Req = 1'b1; iM1Write = 1'b1; iM1ByteEnable = 4'hF; iM1Address = 32'h0000_2000; iM1WriteData = 32'h2222_2222;
        for (int a = 0; a < 4; a++) begin
            m = RR && (a % 2 == 1);
            pushExp(1'b0, m, 1'b0, 32'h0, c0 + 3 * a + 2);
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge iCLK); #1;
            if (k == 11) begin
                iM0Req = 1'b0;
                iM1Req = 1'b0;
            end
            @(negedge iCLK);
            if (k % 3 == 1) begin
                m = RR && (((k - 1) / 3) % 2 == 1);
                g = m ? 2'b10 : 2'b01;
                checkBus("sat_grant", 1'b0, 1'b1, 4'hF, m ? 32'h0000_2000 : 32'h0000_1000,
                         m ? 32'h2222_2222 : 32'h1111_1111, g);
            end
        end

        // READ_LATENCY=3 instance: four read-enable cycles, data from cycle 4 returned in cycle 5.
        @(posedge iCLK); #1;
        c0 = cyc;
        d3M0Req = 1'b1; d3M0Write = 1'b0; d3M0ByteEnable = 4'hF; d3M0Address = 32'h3000_0040;
        rd3Word = 32'h0BAD_CAFE;
        rd3Cycle = c0 + 4;
        pushExp(1'b1, 1'b0, 1'b1, 32'h0BAD_CAFE, c0 + 5);
        for (int k = 1; k <= 6; k++) begin
            @(posedge iCLK); #1;
            if (k == 5) d3M0Req = 1'b0;
            @(negedge iCLK);
            check("rl3_re", 32'(d3ReadEnable), (k <= 4) ? 32'h1 : 32'h0);
            check("rl3_addr", d3Address, (k <= 4) ? 32'h3000_0040 : 32'h0);
        end

        repeat (3) @(negedge iCLK);
        check("pending_acks", 32'(expQ.size() + exp3Q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
